// File: rtl/snn_stdp_layer.sv
`default_nettype none
// ==========================================================================
// snn_stdp_layer -- N_PRE LIF neurons feeding one LIF neuron via STDP synapses
// Rev 1.0
// ==========================================================================
module snn_stdp_layer #(
  parameter int N_PRE   = 4,
  parameter int SW      = 8,
  parameter int WW      = 8,
  parameter int TH_PRE  = 230,
  parameter int TH_POST = 150,
  parameter int LEAK_SH = 3,
  parameter int W_INIT  = 64,
  parameter int A_PLUS  = 8,
  parameter int A_MINUS = 8,
  parameter int TMAX    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_PRE*SW-1:0] current_in,
  input  logic                learn_en,
  output logic [N_PRE-1:0]    pre_spike,
  output logic                post_spike,
  output logic [SW-1:0]       post_state,
  output logic [N_PRE*WW-1:0] weights,
  output logic                w_upd
);

  localparam int c_NW    = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam int c_SUM_W = ((SW > WW) ? SW : WW) + 1 + c_NW;
  localparam int c_TW    = $clog2(TMAX + 1);
  localparam int c_WW1   = WW + 1;
  localparam logic [c_SUM_W-1:0] c_SAT  = c_SUM_W'((64'd1 << SW) - 64'd1);
  localparam logic [c_TW-1:0]    c_TMAX = c_TW'(TMAX);

  logic [SW-1:0]      r_pre_st [N_PRE];
  logic [N_PRE-1:0]   r_pre_spk;
  logic [SW-1:0]      r_post_st;
  logic               r_post_spk;
  logic [WW-1:0]      r_w      [N_PRE];
  logic [c_TW-1:0]    r_pre_t  [N_PRE];
  logic [c_TW-1:0]    r_post_t;
  logic               r_w_upd;

  logic [c_SUM_W-1:0] w_post_sum;
  logic [c_SUM_W-1:0] w_post_cur;
  logic [c_WW1-1:0]   w_ltp    [N_PRE];
  logic [c_WW1-1:0]   w_ltd    [N_PRE];
  logic [WW-1:0]      w_w_nxt  [N_PRE];
  logic               w_w_chg;

  // Accumulator is wide enough that leak + input never wraps before the clamp.
  function automatic logic [SW-1:0] lif_next(input logic [SW-1:0] st,
                                             input logic [c_SUM_W-1:0] cur);
    logic [c_SUM_W-1:0] acc;
    acc = c_SUM_W'(st) - c_SUM_W'(st >> LEAK_SH) + cur;
    return (acc > c_SAT) ? SW'(c_SAT) : acc[SW-1:0];
  endfunction

  function automatic logic [c_TW-1:0] tmr_next(input logic [c_TW-1:0] t);
    return (t == c_TMAX) ? t : t + 1'b1;
  endfunction

  always_comb begin
    w_post_sum = '0;
    for (int i = 0; i < N_PRE; i++)
      if (r_pre_spk[i]) w_post_sum = w_post_sum + c_SUM_W'(r_w[i]);
    w_post_cur = (w_post_sum > c_SAT) ? c_SAT : w_post_sum;
  end

  // Timer at TMAX means no partner spike inside the window, so no pairing.
  always_comb begin
    w_w_chg = 1'b0;
    for (int i = 0; i < N_PRE; i++) begin
      w_ltp[i]   = {1'b0, r_w[i]} + c_WW1'(A_PLUS >> (r_pre_t[i] >> 2));
      w_ltd[i]   = {1'b0, r_w[i]} - c_WW1'(A_MINUS >> (r_post_t >> 2));
      w_w_nxt[i] = r_w[i];
      if (learn_en && r_post_spk && !r_pre_spk[i] && (r_pre_t[i] < c_TMAX))
        w_w_nxt[i] = w_ltp[i][WW] ? '1 : w_ltp[i][WW-1:0];
      else if (learn_en && r_pre_spk[i] && !r_post_spk && (r_post_t < c_TMAX))
        w_w_nxt[i] = w_ltd[i][WW] ? '0 : w_ltd[i][WW-1:0];
      w_w_chg = w_w_chg | (w_w_nxt[i] != r_w[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PRE; i++) begin
        r_pre_st[i] <= '0;
        r_w[i]      <= WW'(W_INIT);
        r_pre_t[i]  <= c_TMAX;
      end
      r_pre_spk  <= '0;
      r_post_st  <= '0;
      r_post_spk <= 1'b0;
      r_post_t   <= c_TMAX;
      r_w_upd    <= 1'b0;
    end else begin
      for (int i = 0; i < N_PRE; i++) begin
        if (r_pre_st[i] >= SW'(TH_PRE)) begin
          r_pre_st[i]  <= '0;
          r_pre_spk[i] <= 1'b1;
        end else begin
          r_pre_st[i]  <= lif_next(r_pre_st[i], c_SUM_W'(current_in[i*SW +: SW]));
          r_pre_spk[i] <= 1'b0;
        end
        r_pre_t[i] <= r_pre_spk[i] ? '0 : tmr_next(r_pre_t[i]);
        r_w[i]     <= w_w_nxt[i];
      end
      if (r_post_st >= SW'(TH_POST)) begin
        r_post_st  <= '0;
        r_post_spk <= 1'b1;
      end else begin
        r_post_st  <= lif_next(r_post_st, w_post_cur);
        r_post_spk <= 1'b0;
      end
      r_post_t <= r_post_spk ? '0 : tmr_next(r_post_t);
      r_w_upd  <= w_w_chg;
    end
  end

  for (genvar i = 0; i < N_PRE; i++) begin : g_pack
    assign weights[i*WW +: WW] = r_w[i];
  end

  assign pre_spike  = r_pre_spk;
  assign post_spike = r_post_spk;
  assign post_state = r_post_st;
  assign w_upd      = r_w_upd;

endmodule
`default_nettype wire

// File: doc/snn_stdp_layer.md
SNN_STDP_LAYER -- requirements
Module: snn_stdp_layer

Interface
REQ-001 SHALL have parameter N_PRE, default 4: number of presynaptic LIF neurons and synapses.
REQ-002 SHALL have parameter SW, default 8: membrane state width.
REQ-003 SHALL have parameter WW, default 8: synaptic weight width.
REQ-004 SHALL have parameters TH_PRE=230, TH_POST=150, LEAK_SH=3 (leak shift), W_INIT=64, A_PLUS=8, A_MINUS=8, TMAX=15 (STDP window, cycles).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port current_in, input, N_PRE*SW: packed per-neuron input currents, neuron i at bits [i*SW +: SW].
REQ-008 SHALL have port learn_en, input, 1: 1 enables weight updates; 0 freezes all weights.
REQ-009 SHALL have port pre_spike, input-side... output, N_PRE: registered presynaptic spikes.
REQ-010 SHALL have port post_spike, output, 1: registered postsynaptic spike.
REQ-011 SHALL have port post_state, output, SW: postsynaptic membrane state register.
REQ-012 SHALL have port weights, output, N_PRE*WW: packed weight registers, synapse i at [i*WW +: WW].
REQ-013 SHALL have port w_upd, output, 1: one-cycle pulse, high in the cycle in which any weight holds a newly changed value.

Function
REQ-014 Every neuron (pre i and post) SHALL update per edge: if state >= TH, then state<=0 and spike<=1; else state<=sat(state - (state>>LEAK_SH) + I) and spike<=0.
REQ-015 sat() SHALL clamp to 2^SW-1; intermediate sums SHALL be computed at least SW+1+clog2(N_PRE) bits wide, never wrap.
REQ-016 Pre neuron i SHALL use I = current_in slice i and TH = TH_PRE.
REQ-017 Post neuron SHALL use TH = TH_POST and I = sat-to-SW of the sum of weights[i] over all i with pre_spike[i]=1 in the current cycle (one-cycle synaptic latency).
REQ-018 Each synapse SHALL have pre_timer[i] (width clog2(TMAX+1)); next = 0 if pre_spike[i] else min(pre_timer[i]+1, TMAX).
REQ-019 A single post_timer SHALL follow the same rule using post_spike.
REQ-020 LTP: in a cycle with post_spike=1, pre_spike[i]=0, pre_timer[i]<TMAX, learn_en=1, weights[i] SHALL become min(weights[i] + (A_PLUS >> (pre_timer[i]>>2)), 2^WW-1) at the next edge.
REQ-021 LTD: in a cycle with pre_spike[i]=1, post_spike=0, post_timer<TMAX, learn_en=1, weights[i] SHALL become max(weights[i] - (A_MINUS >> (post_timer>>2)), 0) at the next edge.
REQ-022 Simultaneous pre_spike[i]=1 and post_spike=1 SHALL leave weights[i] unchanged.
REQ-023 Multiple synapses SHALL update independently in the same cycle; LTP and LTD on different synapses in one cycle SHALL both apply.
REQ-024 A timer equal to TMAX SHALL mean "no spike in window": no update from that pairing.
REQ-025 w_upd SHALL be registered: high for one cycle after an edge at which at least one weight register changed value; a saturated update producing no change SHALL NOT assert w_upd.
REQ-026 learn_en=0 SHALL not affect neuron dynamics or timers.

Reset
REQ-027 On rst_n=0, asynchronously: all membrane states 0, pre_spike=0, post_spike=0, post_state=0, w_upd=0.
REQ-028 On rst_n=0: all weights = W_INIT, all timers = TMAX (no pairing history).
REQ-029 Reset asserted mid-operation SHALL discard pending updates; first update after release requires fresh spikes.

Verification
REQ-030 Reset, current_in all 255 -> pre state 255 after edge 1; pre_spike=1 after edge 2, and every 2nd cycle thereafter; post_spike=0 after edge 2.
REQ-031 Defaults, all 4 pre spike together -> post current 256 saturates to 255; post_state=255 one edge later, post_spike=1 the following edge.
REQ-032 Pre 0 spikes, post spikes 3 cycles later (pre_timer=2), learn_en=1 -> weights[0]=72 at next edge, w_upd=1 for one cycle; other weights stay 64.
REQ-033 Post spikes, pre 1 spikes with post_timer=5 -> weights[1]=64-(8>>1)=60.
REQ-034 weights[2] driven to 255 by repeated LTP -> stays 255, no w_upd; learn_en=0 with same pairings -> no weight change.
REQ-035 Pre and post spike same cycle -> no change; assert rst_n mid-run -> weights return to 64, timers to 15, outputs 0 immediately.
